// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg : shared FSM encoding and default sizing for the UART RX path  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package uart_pkg;

   typedef logic [1:0] rx_state_t;

   localparam rx_state_t ST_OFF      = 2'b00;
   localparam rx_state_t ST_ARMED    = 2'b01;
   localparam rx_state_t ST_ACTIVE   = 2'b10;
   localparam rx_state_t ST_STOPPING = 2'b11;

   localparam int UART_DATA_WIDTH = 8;
   localparam int CLK_FREQ_MHZ    = 125;
   localparam int BAUDRATE        = 115200;
   localparam int FRAME_BITS      = 10;
   localparam int TIMEOUT_CHARS   = 4;

   // Whole clocks per bit first, so the result is a clean multiple of a bit time.
   function automatic int calc_timeout(input int clk_mhz, input int baud);
      int bit_cycles;
      bit_cycles = (clk_mhz * 1000000) / baud;
      return TIMEOUT_CHARS * FRAME_BITS * bit_cycles;
   endfunction

   localparam int UART_TIMEOUT_CYCLES = calc_timeout(CLK_FREQ_MHZ, BAUDRATE);

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_fifo : synchronous first-word-fall-through byte FIFO with flush  |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module uart_rx_fifo import uart_pkg::*; #(
   parameter int DATA_WIDTH = UART_DATA_WIDTH,
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   input  logic                  flush_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [FIFO_AW:0]      level_o,
   output logic                  full_o,
   output logic                  empty_o
);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0]    head_q, head_d;
   logic [FIFO_AW-1:0]    tail_q, tail_d;
   logic [FIFO_AW:0]      level_q, level_d;
   logic                  pop_ok;
   logic                  push_ok;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == (FIFO_AW+1)'(FIFO_DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      level_d = level_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         level_d = '0;
      end else begin
         if (push_ok) tail_d = tail_q + FIFO_AW'(1);
         if (pop_ok)  head_d = head_q + FIFO_AW'(1);
         level_d = level_q + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         level_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         level_q <= level_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok && !flush_i) mem_q[tail_q] <= data_i;
   end

   assign data_o  = empty_o ? '0 : mem_q[head_q];
   assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_ctrl : RX enable sequencing, byte buffering, overrun/timeout irq |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module uart_rx_ctrl import uart_pkg::*; #(
   parameter int DATA_WIDTH     = UART_DATA_WIDTH,
   parameter int FIFO_DEPTH     = 8,
   parameter int FIFO_AW        = $clog2(FIFO_DEPTH),
   parameter int TIMEOUT_CYCLES = UART_TIMEOUT_CYCLES
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  cfg_rx_enable_i,
   input  logic [FIFO_AW:0]      cfg_threshold_i,
   input  logic                  flush_i,
   input  logic [1:0]            clr_status_i,
   input  logic                  rx_done_i,
   input  logic [DATA_WIDTH-1:0] rx_data_i,
   input  logic                  rx_busy_i,
   output logic                  rx_en_o,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   input  logic                  pop_i,
   output logic [FIFO_AW:0]      fifo_level_o,
   output logic                  overrun_o,
   output logic                  timeout_o,
   output logic                  irq_o
);

   localparam int             CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   rx_state_t        state_q, state_d;
   logic             rx_en_q, rx_en_d;
   logic             overrun_q, overrun_d;
   logic             timeout_q, timeout_d;
   logic             irq_q, irq_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [FIFO_AW:0] level;
   logic             full;
   logic             empty;
   logic             drop;
   logic             cnt_clr;

   uart_rx_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .FIFO_AW    (FIFO_AW)
   ) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (rx_done_i),
      .data_i  (rx_data_i),
      .pop_i   (pop_i),
      .flush_i (flush_i),
      .data_o  (rd_data_o),
      .level_o (level),
      .full_o  (full),
      .empty_o (empty)
   );

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= ST_OFF;
         rx_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rx_en_q <= rx_en_d;
      end
   end

   // A busy line always wins over disable so a started frame is finished.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_OFF:      if (cfg_rx_enable_i) state_d = ST_ARMED;
         ST_ARMED: begin
            if (rx_busy_i)             state_d = cfg_rx_enable_i ? ST_ACTIVE : ST_STOPPING;
            else if (!cfg_rx_enable_i) state_d = ST_OFF;
         end
         ST_ACTIVE: begin
            if (!rx_busy_i) state_d = cfg_rx_enable_i ? ST_ARMED : ST_OFF;
            else if (!cfg_rx_enable_i) state_d = ST_STOPPING;
         end
         ST_STOPPING: if (!rx_busy_i) state_d = ST_OFF;
         default:     state_d = ST_OFF;
      endcase
   end

   always_comb begin
      rx_en_d = (state_d != ST_OFF);
   end

   // Flush discards a coincident byte silently, so it never counts as a drop.
   assign drop    = rx_done_i && full && !(pop_i && !empty) && !flush_i;
   assign cnt_clr = rx_done_i || pop_i || flush_i || (level == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)                         cnt_d = '0;
      else if (!rx_busy_i && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      overrun_d = drop || (overrun_q && !clr_status_i[0]);
      timeout_d = (cnt_q == CNT_MAX) || (timeout_q && !clr_status_i[1]);
      irq_d     = ((cfg_threshold_i != '0) && (level >= cfg_threshold_i))
                  || overrun_q || timeout_q;
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         cnt_q     <= '0;
         overrun_q <= 1'b0;
         timeout_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
         timeout_q <= timeout_d;
         irq_q     <= irq_d;
      end
   end

   assign rx_en_o      = rx_en_q;
   assign rd_valid_o   = !empty;
   assign fifo_level_o = level;
   assign overrun_o    = overrun_q;
   assign timeout_o    = timeout_q;
   assign irq_o        = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_ctrl : scoreboard bench for uart_rx_ctrl (timeout = 16 clks)  |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_uart_rx_ctrl;

   logic       clk = 1'b0;
   logic       rstn;
   logic       cfg_rx_enable;
   logic [3:0] cfg_threshold;
   logic       flush;
   logic [1:0] clr_status;
   logic       rx_done;
   logic [7:0] rx_data;
   logic       rx_busy;
   logic       rx_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       pop;
   logic [3:0] fifo_level;
   logic       overrun;
   logic       timeout;
   logic       irq;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;

   always #5 clk = ~clk;

   uart_rx_ctrl #(
      .DATA_WIDTH     (8),
      .FIFO_DEPTH     (8),
      .FIFO_AW        (3),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i           (clk),
      .rstn_i          (rstn),
      .cfg_rx_enable_i (cfg_rx_enable),
      .cfg_threshold_i (cfg_threshold),
      .flush_i         (flush),
      .clr_status_i    (clr_status),
      .rx_done_i       (rx_done),
      .rx_data_i       (rx_data),
      .rx_busy_i       (rx_busy),
      .rx_en_o         (rx_en),
      .rd_data_o       (rd_data),
      .rd_valid_o      (rd_valid),
      .pop_i           (pop),
      .fifo_level_o    (fifo_level),
      .overrun_o       (overrun),
      .timeout_o       (timeout),
      .irq_o           (irq)
   );

   // Every accepted pop must present the oldest byte still owed by the scoreboard.
   always @(negedge clk) begin
      if (rstn && pop && rd_valid) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_pop: got %02h with nothing expected", rd_data);
         end else begin
            exp_b = exp_q.pop_front();
            if (rd_data !== exp_b) begin
               n_err++;
               $display("FAIL sb_pop: got %02h expected %02h", rd_data, exp_b);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input bit store);
      rx_done = 1'b1;
      rx_data = d;
      if (store) exp_q.push_back(d);
      cyc();
      rx_done = 1'b0;
   endtask

   task automatic do_pop();
      pop = 1'b1;
      cyc();
      pop = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; cfg_rx_enable = 1'b0; cfg_threshold = 4'd0; flush = 1'b0;
      clr_status = 2'b00; rx_done = 1'b0; rx_data = 8'h00; rx_busy = 1'b1; pop = 1'b0;
      repeat (3) cyc();
      chk("rst_rx_en", rx_en, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_irq", irq, 0);
      rstn = 1'b1;
      cyc();

      // basic enable and ordered readout
      cfg_rx_enable = 1'b1;
      cyc();
      chk("en_rx_en", rx_en, 1);
      push(8'hA5, 1); push(8'h3C, 1); push(8'hFF, 1);
      chk("basic_level", fifo_level, 3);
      chk("basic_valid", rd_valid, 1);
      repeat (3) do_pop();
      chk("basic_empty", rd_valid, 0);

      // fill threshold interrupt
      cfg_threshold = 4'd4;
      push(8'h01, 1); push(8'h02, 1); push(8'h03, 1);
      cyc();
      chk("thr_irq_below", irq, 0);
      push(8'h04, 1);
      chk("thr_irq_latency", irq, 0);
      cyc();
      chk("thr_irq_set", irq, 1);
      do_pop();
      chk("thr_irq_hold", irq, 1);
      cyc();
      chk("thr_irq_clr", irq, 0);
      repeat (3) do_pop();
      cfg_threshold = 4'd0;

      // overrun and push+pop on a full FIFO
      for (int i = 0; i < 8; i++) push(8'h80 + 8'(i), 1);
      chk("full_level", fifo_level, 8);
      chk("full_no_ovr", overrun, 0);
      push(8'h11, 0);
      chk("ovr_set", overrun, 1);
      chk("ovr_level", fifo_level, 8);
      chk("ovr_head", rd_data, 8'h80);
      rx_done = 1'b1; rx_data = 8'h22; pop = 1'b1; exp_q.push_back(8'h22);
      cyc();
      rx_done = 1'b0; pop = 1'b0;
      chk("pp_level", fifo_level, 8);
      chk("pp_ovr", overrun, 1);
      clr_status = 2'b01;
      cyc();
      clr_status = 2'b00;
      chk("ovr_clr", overrun, 0);
      repeat (8) do_pop();
      chk("drain_empty", rd_valid, 0);

      // graceful stop around a frame in progress
      cfg_rx_enable = 1'b0;
      cyc();
      chk("stop_rx_en0", rx_en, 1);
      cyc(); cyc();
      chk("stop_rx_en1", rx_en, 1);
      push(8'h5A, 1);
      chk("stop_rx_en2", rx_en, 1);
      rx_busy = 1'b0;
      cyc();
      chk("stop_rx_off", rx_en, 0);
      chk("stop_level", fifo_level, 1);
      do_pop();

      // idle timeout: 16 clocks after the push
      push(8'h77, 1);
      chk("to_start", timeout, 0);
      repeat (15) cyc();
      chk("to_early", timeout, 0);
      cyc();
      chk("to_set", timeout, 1);
      chk("to_irq_lat", irq, 0);
      cyc();
      chk("to_irq", irq, 1);
      do_pop();
      clr_status = 2'b10;
      cyc();
      clr_status = 2'b00;
      chk("to_clr", timeout, 0);
      cyc();
      chk("to_irq_clr", irq, 0);
      push(8'h78, 1);
      repeat (9) cyc();
      do_pop();
      repeat (20) cyc();
      chk("to_pop_none", timeout, 0);
      chk("to_pop_irq", irq, 0);
      rx_busy = 1'b1;

      // flush dominates a coincident push
      for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1);
      chk("fl_level5", fifo_level, 5);
      flush = 1'b1; rx_done = 1'b1; rx_data = 8'h99;
      exp_q.delete();
      cyc();
      flush = 1'b0; rx_done = 1'b0;
      chk("fl_level", fifo_level, 0);
      chk("fl_valid", rd_valid, 0);
      chk("fl_ovr", overrun, 0);
      chk("fl_data", rd_data, 0);
      push(8'h42, 1);
      chk("fl_refill", fifo_level, 1);
      do_pop();
      chk("fl_reempty", fifo_level, 0);

      // reset mid-fill
      cfg_rx_enable = 1'b1;
      cfg_threshold = 4'd2;
      push(8'hE1, 1); push(8'hE2, 1); push(8'hE3, 1);
      cyc();
      chk("mr_pre_irq", irq, 1);
      chk("mr_pre_en", rx_en, 1);
      rstn = 1'b0;
      exp_q.delete();
      cyc();
      chk("mr_rx_en", rx_en, 0);
      chk("mr_valid", rd_valid, 0);
      chk("mr_data", rd_data, 0);
      chk("mr_level", fifo_level, 0);
      chk("mr_overrun", overrun, 0);
      chk("mr_timeout", timeout, 0);
      chk("mr_irq", irq, 0);
      cfg_rx_enable = 1'b0;
      cfg_threshold = 4'd0;
      rstn = 1'b1;
      cyc();

      chk("sb_leftover", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller between the UART receiver core and the APB register slave. Sequences the receiver enable (graceful start/stop around frames), buffers received bytes in a small synchronous FIFO, and flags overrun and idle-timeout conditions. Raises a level interrupt toward the APB interrupt line.

Parameters:
DATA_WIDTH, 8, byte width; matches the receiver core data_o.
FIFO_DEPTH, 8, entries; power of two, at least 2.
FIFO_AW, $clog2(FIFO_DEPTH), FIFO pointer width.
TIMEOUT_CYCLES, 43400, idle clocks with data pending before timeout (4 chars at 125 MHz / 115200 baud).

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
cfg_rx_enable  in  1  software receive enable
cfg_threshold  in  FIFO_AW+1  irq fill threshold; 0 disables the threshold term
flush  in  1  one-cycle pulse: empty the FIFO
clr_status  in  2  one-cycle pulses: [0] clear overrun, [1] clear timeout
rx_done  in  1  one-cycle pulse from the receiver core: byte valid
rx_data  in  DATA_WIDTH  received byte, valid when rx_done=1
rx_busy  in  1  receiver core frame in progress
rx_en  out  1  enable to the receiver core
rd_data  out  DATA_WIDTH  FIFO head byte
rd_valid  out  1  FIFO not empty
pop  in  1  consume head; ignored when rd_valid=0
fifo_level  out  FIFO_AW+1  current entry count, 0..FIFO_DEPTH
overrun  out  1  sticky: byte dropped on a full FIFO
timeout  out  1  sticky: idle timeout fired
irq  out  1  registered interrupt

Behaviour:
- Reset (synchronous, rstn=0 at a clk edge): state OFF, FIFO empty, rx_en=0, rd_valid=0, rd_data=0, fifo_level=0, overrun=0, timeout=0, irq=0, timeout counter=0.
- FSM states: OFF, ARMED, ACTIVE, STOPPING. Encoding lives in the package.
  - OFF -> ARMED when cfg_rx_enable=1.
  - ARMED -> ACTIVE when rx_busy=1. ARMED -> OFF when cfg_rx_enable=0.
  - ACTIVE -> ARMED when rx_busy=0 and cfg_rx_enable=1. ACTIVE -> STOPPING when cfg_rx_enable=0 while rx_busy=1.
  - STOPPING -> OFF when rx_busy=0. A re-enable during STOPPING is taken on return to OFF, never mid-frame.
- rx_en is registered and equals 1 in ARMED, ACTIVE and STOPPING. A frame in progress is never cut off by disable.
- Push: rx_done=1 with the FIFO not full writes rx_data at the tail; fifo_level increments on the next cycle. rx_done is accepted in every state, including OFF.
- Full: rx_done=1 with fifo_level=FIFO_DEPTH and no pop drops the byte and sets overrun the next cycle. FIFO contents are unchanged.
- Pop: pop=1 with rd_valid=1 advances the head. rd_data is the combinational head (first-word-fall-through); the next byte is visible the cycle after the pop.
- Simultaneous push and pop:
  - FIFO full: both succeed, level is unchanged, no overrun.
  - FIFO empty: the pop is ignored and the push succeeds.
- Flush: FIFO is emptied next cycle and dominates a same-cycle push or pop (the pushed byte is discarded with no overrun). Sticky flags are unaffected.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is kept as a separate count.
- Timeout counter:
  - Clears on rx_done, pop, flush, or when fifo_level=0.
  - Otherwise increments while rx_busy=0 and saturates at TIMEOUT_CYCLES-1.
  - On reaching TIMEOUT_CYCLES-1, timeout is set on the next cycle.
- Sticky clears: clr_status[0] clears overrun and clr_status[1] clears timeout. A same-cycle set event wins over the clear.
- irq is registered: (cfg_threshold!=0 and fifo_level>=cfg_threshold) or overrun or timeout, with 1-cycle latency from the flag or level change.

Decomposition:
- Package uart_pkg holds: FSM state localparams (OFF=2'b00, ARMED=2'b01, ACTIVE=2'b10, STOPPING=2'b11), DATA_WIDTH default, and the TIMEOUT_CYCLES derivation from CLK_FREQ_MHZ and BAUDRATE.
- One sub-module: uart_rx_fifo (synchronous FWFT FIFO with push, pop, flush, level, full and empty).
- The FSM, sticky flags, timeout counter and irq stay in uart_rx_ctrl.

Test Plan:
- Enable, then 3 rx_done pulses with 0xA5, 0x3C, 0xFF -> rx_en=1 one cycle after enable; fifo_level=3; pops return A5, 3C, FF in order; rd_valid=0 after the third pop.
- cfg_threshold=4, push 4 bytes -> irq=1 one cycle after level reaches 4; one pop -> irq=0 one cycle later.
- Fill 8 bytes, push 0x11 -> overrun=1, level=8, head unchanged. Push 0x22 with a simultaneous pop -> no further effect on overrun, level stays 8, tail=0x22. clr_status[0] -> overrun=0.
- Drop cfg_rx_enable while rx_busy=1 -> state STOPPING, rx_en stays 1 until rx_busy falls, then rx_en=0 next cycle; the byte completing in STOPPING is stored.
- TIMEOUT_CYCLES=16 override, push 1 byte, keep rx_busy=0 -> timeout=1 exactly 16 cycles after the push and irq=1 one cycle later. Repeat with a pop at cycle 10 -> no timeout.
- Flush coincident with rx_done on a 5-entry FIFO -> level=0, rd_valid=0, overrun unchanged. Reset mid-fill -> all outputs return to reset values on the next edge.
